tt_response_collector: RTL and testbench

Captures a single-bit DUT response for each N-bit input vector presented on a valid/ready stream, and builds the full truth table plus a MISR signature of the (vector, response) sequence. It is the capture end of the exhaustive-vector stimulus flow in the trojan-detection benches: the stimulus side walks all 2^N input patterns, and this block receives each pattern with its response and reports the result in hardware. It is used wherever per-vector results must be compared on-chip rather than dumped to a file.

---
 rtl/tt_collect_pkg.sv | 33 +++
 rtl/tt_misr.sv | 40 ++++
 rtl/tt_response_collector.sv | 137 +++++++++++++
 tb/tb_tt_response_collector.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_collect_pkg.sv
// ----------------------------------------------------------------------------
// tt_collect_pkg
// Shared types and helpers for the truth-table response collector.
//   tt_state_e       : collector FSM state (IDLE, COLLECT, DONE)
//   TT_DEFAULT_POLY  : default MISR feedback polynomial (16-bit)
//   misr_step()      : one MISR shift/compress step, used by RTL and models
// ----------------------------------------------------------------------------
package tt_collect_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } tt_state_e;

    localparam logic [15:0] TT_DEFAULT_POLY = 16'h8005;

    // One MISR step on a signature of width w (1..32). Operands are carried
    // in 32-bit containers; bits above w are masked off in the result.
    function automatic logic [31:0] misr_step(
        input logic [31:0] sig,
        input logic [31:0] data,
        input logic [31:0] poly,
        input int unsigned w = 16
    );
        logic [31:0] mask;
        logic        msb;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        msb  = |((sig >> (w - 1)) & 32'd1);
        return ((sig << 1) ^ (msb ? poly : 32'd0) ^ data) & mask;
    endfunction

endpackage

// File: rtl/tt_misr.sv
// ----------------------------------------------------------------------------
// tt_misr
// SIG_W-wide multiple-input signature register (SIG_W <= 32).
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, clears the signature
//   clr_i  : synchronous clear (start of a new run)
//   en_i   : compress data_i into the signature this cycle
//   data_i : parallel input word
//   sig_o  : current signature
// ----------------------------------------------------------------------------
module tt_misr
    import tt_collect_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(TT_DEFAULT_POLY)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [SIG_W-1:0] data_i,
    output logic [SIG_W-1:0] sig_o
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    assign sig_d = SIG_W'(misr_step(32'(sig_q), 32'(data_i), 32'(POLY), SIG_W));

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sig_q <= '0;
        end else if (en_i) begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/tt_response_collector.sv
// ----------------------------------------------------------------------------
// tt_response_collector
// Captures one response bit per N_IN-bit input vector from a valid/ready
// stream, building the full truth table and a MISR signature of the
// (vector, response) sequence.
//   CK, reset      : clock, synchronous active-high reset
//   start          : begin a run (honoured in IDLE and DONE)
//   in_valid/ready : pair handshake; in_ready high only in COLLECT
//   in_vec/in_resp : applied vector and observed response
//   busy / done    : in COLLECT / in DONE (levels)
//   timeout        : run ended by TIMEOUT idle cycles (sticky)
//   dup_err        : some vector was received twice (sticky)
//   tt_out / seen  : captured responses / capture flags, bit i = vector i
//   signature      : MISR state
//   count          : number of distinct vectors captured
// ----------------------------------------------------------------------------
module tt_response_collector
    import tt_collect_pkg::*;
#(
    parameter int unsigned      N_IN    = 3,
    parameter int unsigned      SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = SIG_W'(TT_DEFAULT_POLY),
    parameter int unsigned      TIMEOUT = 64
) (
    input  logic                   CK,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N_IN-1:0]        in_vec,
    input  logic                   in_resp,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic                   dup_err,
    output logic [(1<<N_IN)-1:0]   tt_out,
    output logic [(1<<N_IN)-1:0]   seen,
    output logic [SIG_W-1:0]       signature,
    output logic [N_IN:0]          count
);

    localparam int unsigned NV = 1 << N_IN;
    localparam int unsigned IW = $clog2(TIMEOUT + 1);
    localparam logic [N_IN:0]  FULL      = (N_IN + 1)'(NV);
    localparam logic [IW-1:0]  IDLE_LAST = IW'(TIMEOUT - 1);

    tt_state_e         state_q;
    logic [NV-1:0]     tt_q;
    logic [NV-1:0]     seen_q;
    logic [N_IN:0]     count_q;
    logic [N_IN:0]     count_d;
    logic [IW-1:0]     idle_q;
    logic              to_q;
    logic              dup_q;

    logic              accept;
    logic              run_start;

    // in_ready is a decode of the state register only, so accept never
    // loops back through in_valid.
    assign accept    = in_valid && (state_q == COLLECT);
    assign run_start = start && (state_q != COLLECT);
    assign count_d   = count_q + 1'b1;

    always_ff @(posedge CK) begin
        if (reset) begin
            state_q <= IDLE;
            tt_q    <= '0;
            seen_q  <= '0;
            count_q <= '0;
            idle_q  <= '0;
            to_q    <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= COLLECT;
                        tt_q    <= '0;
                        seen_q  <= '0;
                        count_q <= '0;
                        idle_q  <= '0;
                        to_q    <= 1'b0;
                        dup_q   <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        // An accept always wins over a same-cycle timeout.
                        idle_q <= '0;
                        if (seen_q[in_vec]) begin
                            dup_q <= 1'b1;  // first capture is kept
                        end else begin
                            tt_q[in_vec]   <= in_resp;
                            seen_q[in_vec] <= 1'b1;
                            count_q        <= count_d;
                            if (count_d == FULL) begin
                                state_q <= DONE;
                            end
                        end
                    end else begin
                        if (idle_q != '1) begin
                            idle_q <= idle_q + 1'b1;
                        end
                        if (idle_q == IDLE_LAST) begin
                            state_q <= DONE;
                            to_q    <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    tt_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk_i  (CK),
        .rst_i  (reset),
        .clr_i  (run_start),
        .en_i   (accept),
        .data_i (SIG_W'({in_vec, in_resp})),
        .sig_o  (signature)
    );

    assign in_ready = (state_q == COLLECT);
    assign busy     = (state_q == COLLECT);
    assign done     = (state_q == DONE);
    assign timeout  = to_q;
    assign dup_err  = dup_q;
    assign tt_out   = tt_q;
    assign seen     = seen_q;
    assign count    = count_q;

endmodule

// File: tb/tb_tt_response_collector.sv
module tb_tt_response_collector;
    import tt_collect_pkg::*;

    localparam int N  = 3;
    localparam int SW = 16;
    localparam int TO = 20;

    logic        CK = 1'b0;
    logic        reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_resp = 1'b0;
    logic [2:0]  in_vec = '0;
    logic        in_ready, busy, done, timeout, dup_err;
    logic [7:0]  tt_out, seen;
    logic [15:0] signature;
    logic [3:0]  count;

    int checks = 0;
    int failures = 0;

    // Behavioural reference: state as 0=idle 1=collect 2=done, captured
    // table as plain bit arrays, quiet = cycles since last accept.
    int          m_st;
    logic [7:0]  m_tt, m_seen;
    logic [15:0] m_sig;
    logic        m_dup, m_to;
    int          m_quiet;

    always #5 CK = ~CK;

    tt_response_collector #(.N_IN(N), .SIG_W(SW), .POLY(16'h8005), .TIMEOUT(TO)) dut (
        .CK(CK), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_vec(in_vec), .in_resp(in_resp), .busy(busy), .done(done), .timeout(timeout),
        .dup_err(dup_err), .tt_out(tt_out), .seen(seen), .signature(signature), .count(count)
    );

    function automatic logic [15:0] step16(input logic [15:0] s, input logic [2:0] v, input logic r);
        return 16'(misr_step(32'(s), 32'({v, r}), 32'(TT_DEFAULT_POLY), SW));
    endfunction

    task automatic m_clear();
        m_tt = '0; m_seen = '0; m_sig = '0; m_dup = 1'b0; m_to = 1'b0; m_quiet = 0;
    endtask

    task automatic model_edge(input logic rst, input logic s, input logic v,
                              input logic [2:0] vec, input logic r);
        if (rst) begin
            m_st = 0; m_clear();
        end else if (m_st != 1) begin
            if (s) begin m_clear(); m_st = 1; end
        end else if (v) begin
            if (m_seen[vec]) m_dup = 1'b1;
            else begin m_tt[vec] = r; m_seen[vec] = 1'b1; end
            m_sig = step16(m_sig, vec, r);
            m_quiet = 0;
            if (m_seen == 8'hFF) m_st = 2;
        end else begin
            m_quiet++;
            if (m_quiet >= TO) begin m_st = 2; m_to = 1'b1; end
        end
    endtask

    // Drive one cycle's inputs, take the edge, sample 1 time unit later.
    task automatic drive_cycle(input logic rst, input logic s, input logic v,
                               input logic [2:0] vec, input logic r);
        reset = rst; start = s; in_valid = v; in_vec = vec; in_resp = r;
        @(posedge CK);
        model_edge(rst, s, v, vec, r);
        #1;
    endtask

    task automatic fresh_start();
        drive_cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        drive_cycle(1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if ({timeout, dup_err} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {timeout, dup_err}); end
        checks++; if ({tt_out, seen} !== 16'h0) begin failures++; $display("FAIL reset_table got=%h exp=0000", {tt_out, seen}); end
        checks++; if (signature !== 16'h0) begin failures++; $display("FAIL reset_sig got=%h exp=0000", signature); end
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    endtask

    task automatic test_exhaustive();
        logic [15:0] gold;
        fresh_start();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL exh_ready got=%b exp=1", in_ready); end
        gold = '0;
        for (int v = 0; v < 8; v++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, 3'(v), ^3'(v));
            gold = step16(gold, 3'(v), ^3'(v));
            checks++; if (count !== 4'(v + 1)) begin failures++; $display("FAIL exh_count v=%0d got=%0d exp=%0d", v, count, v + 1); end
            if (v == 6) begin
                checks++; if (done !== 1'b0) begin failures++; $display("FAIL exh_early_done got=%b exp=0", done); end
            end
        end
        in_valid = 1'b0;
        checks++; if ({done, busy} !== 2'b10) begin failures++; $display("FAIL exh_done_busy got=%b exp=10", {done, busy}); end
        checks++; if (tt_out !== 8'h96) begin failures++; $display("FAIL exh_tt got=%h exp=96", tt_out); end
        checks++; if (seen !== 8'hFF) begin failures++; $display("FAIL exh_seen got=%h exp=ff", seen); end
        checks++; if (signature !== gold) begin failures++; $display("FAIL exh_sig got=%h exp=%h", signature, gold); end
    endtask

    task automatic test_out_of_order();
        logic [2:0]  order [8] = '{3'd7, 3'd0, 3'd5, 3'd2, 3'd1, 3'd6, 3'd3, 3'd4};
        logic [15:0] gold, inorder;
        fresh_start();
        gold = '0; inorder = '0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 1'b0, 1'b1, order[i], 1'b1);
            gold = step16(gold, order[i], 1'b1);
            inorder = step16(inorder, 3'(i), 1'b1);
        end
        in_valid = 1'b0;
        checks++; if (tt_out !== 8'hFF) begin failures++; $display("FAIL ooo_tt got=%h exp=ff", tt_out); end
        checks++; if (signature !== gold) begin failures++; $display("FAIL ooo_sig got=%h exp=%h", signature, gold); end
        checks++; if (signature === inorder) begin failures++; $display("FAIL ooo_sig_distinct got=%h exp=not %h", signature, inorder); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL ooo_done got=%b exp=1", done); end
    endtask

    task automatic test_duplicate();
        logic [15:0] one, two;
        fresh_start();
        drive_cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b1);
        drive_cycle(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
        in_valid = 1'b0;
        one = step16(16'h0, 3'd3, 1'b1);
        two = step16(one, 3'd3, 1'b0);
        checks++; if (tt_out[3] !== 1'b1) begin failures++; $display("FAIL dup_tt3 got=%b exp=1", tt_out[3]); end
        checks++; if (dup_err !== 1'b1) begin failures++; $display("FAIL dup_err got=%b exp=1", dup_err); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL dup_count got=%0d exp=1", count); end
        checks++; if (signature !== two) begin failures++; $display("FAIL dup_sig got=%h exp=%h", signature, two); end
    endtask

    task automatic test_timeout();
        fresh_start();
        for (int v = 0; v < 5; v++) drive_cycle(1'b0, 1'b0, 1'b1, 3'(v), 1'($urandom_range(0, 1)));
        for (int i = 0; i < TO - 1; i++) drive_cycle(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++; if ({done, busy} !== 2'b01) begin failures++; $display("FAIL to_early got=%b exp=01", {done, busy}); end
        drive_cycle(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        checks++; if ({done, timeout} !== 2'b11) begin failures++; $display("FAIL to_done got=%b exp=11", {done, timeout}); end
        checks++; if (count !== 4'd5) begin failures++; $display("FAIL to_count got=%0d exp=5", count); end
        checks++; if (seen !== 8'h1F) begin failures++; $display("FAIL to_seen got=%h exp=1f", seen); end
        checks++; if (tt_out !== m_tt) begin failures++; $display("FAIL to_tt got=%h exp=%h", tt_out, m_tt); end
    endtask

    task automatic test_back_pressure_restart();
        logic [15:0] held;
        fresh_start();
        for (int v = 0; v < 8; v++) drive_cycle(1'b0, 1'b0, 1'b1, 3'(v), 1'b0);
        held = m_sig;
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 1'b1, 3'd6, 1'b1);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
        checks++; if ({count, tt_out} !== {4'd8, 8'h00}) begin failures++; $display("FAIL bp_held got=%h exp=800", {count, tt_out}); end
        checks++; if (signature !== held) begin failures++; $display("FAIL bp_sig got=%h exp=%h", signature, held); end
        drive_cycle(1'b0, 1'b1, 1'b1, 3'd6, 1'b1);
        checks++; if ({busy, count, seen, tt_out} !== 21'h100000) begin failures++; $display("FAIL bp_restart got=%h exp=100000", {busy, count, seen, tt_out}); end
        checks++; if (signature !== 16'h0) begin failures++; $display("FAIL bp_restart_sig got=%h exp=0000", signature); end
        drive_cycle(1'b0, 1'b0, 1'b1, 3'd6, 1'b1);
        in_valid = 1'b0;
        checks++; if ({count, seen} !== {4'd1, 8'h40}) begin failures++; $display("FAIL bp_resume got=%h exp=140", {count, seen}); end
    endtask

    task automatic test_timeout_race();
        fresh_start();
        for (int v = 0; v < 7; v++) drive_cycle(1'b0, 1'b0, 1'b1, 3'(v), 1'b1);
        for (int i = 0; i < TO - 1; i++) drive_cycle(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 3'd7, 1'b1);
        in_valid = 1'b0;
        checks++; if ({done, timeout} !== 2'b10) begin failures++; $display("FAIL race_flags got=%b exp=10", {done, timeout}); end
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL race_count got=%0d exp=8", count); end
    endtask

    task automatic test_reset_mid_run();
        fresh_start();
        for (int v = 0; v < 3; v++) drive_cycle(1'b0, 1'b0, 1'b1, 3'(v + 2), 1'b1);
        drive_cycle(1'b1, 1'b0, 1'b1, 3'd6, 1'b1);
        checks++; if ({in_ready, busy, done} !== 3'b000) begin failures++; $display("FAIL rst_mid_state got=%b exp=000", {in_ready, busy, done}); end
        checks++; if ({tt_out, seen, count} !== 20'h0) begin failures++; $display("FAIL rst_mid_table got=%h exp=00000", {tt_out, seen, count}); end
        checks++; if (signature !== 16'h0) begin failures++; $display("FAIL rst_mid_sig got=%h exp=0000", signature); end
        drive_cycle(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic test_random();
        logic s, v, r;
        logic [2:0] vec;
        int bad;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            s   = ($urandom_range(0, 11) == 0);
            v   = ($urandom_range(0, 9) < 7);
            vec = 3'($urandom_range(0, 7));
            r   = 1'($urandom_range(0, 1));
            drive_cycle(1'b0, s, v, vec, r);
            checks++;
            if ({in_ready, busy, done} !== {m_st == 1, m_st == 1, m_st == 2} ||
                tt_out !== m_tt || seen !== m_seen || count !== 4'($countones(m_seen)) ||
                signature !== m_sig || dup_err !== m_dup || timeout !== m_to) begin
                failures++;
                if (bad < 5) $display("FAIL rand c=%0d got st=%b tt=%h seen=%h cnt=%0d sig=%h dup=%b to=%b exp st=%0d tt=%h seen=%h sig=%h dup=%b to=%b",
                                      c, {in_ready, busy, done}, tt_out, seen, count, signature, dup_err, timeout,
                                      m_st, m_tt, m_seen, m_sig, m_dup, m_to);
                bad++;
            end
        end
        in_valid = 1'b0; start = 1'b0;
    endtask

    initial begin
        m_st = 0; m_clear();
        #1;
        test_reset();
        test_exhaustive();
        test_out_of_order();
        test_duplicate();
        test_timeout();
        test_back_pressure_restart();
        test_timeout_race();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
